// File: rtl/simple_pkg.sv
`default_nettype none
// ============================================================================
// Module      : simple_pkg
// Description : Shared types and constants for the SIMPLE phase sequencer.
//               Holds the sequencer state encoding, the fixed indices of the
//               fetch and decode phases, and the upper bound on phase count.
// Revision    : 1.0 - initial release
// ============================================================================
package simple_pkg;

    // Sequencer control state
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } seq_state_t;

    // Phase 0 is always fetch and phase 1 is always decode; neither can be skipped
    localparam int PH_FETCH   = 0;
    localparam int PH_DECODE  = 1;

    // Largest supported phase count
    localparam int NPHASE_MAX = 16;

endpackage : simple_pkg
`default_nettype wire

// File: rtl/simple_next_phase.sv
`default_nettype none
// ============================================================================
// Module      : simple_next_phase
// Description : Combinational priority search for the next phase. Starting
//               just above the active one-hot phase, picks the lowest index
//               whose mask bit is clear. If no such index exists the current
//               phase is the last of the instruction.
// Revision    : 1.0 - initial release
//
// Parameters  : NPHASE        number of phases
// Ports       : i_phase       current one-hot phase
//               i_mask        skip mask in effect (1 = skip that phase)
//               o_next_phase  one-hot next phase (all zero when last)
//               o_is_last     current phase is the final one
// ============================================================================
module simple_next_phase #(
    parameter int NPHASE = 5
) (
    input  logic [NPHASE-1:0] i_phase,
    input  logic [NPHASE-1:0] i_mask,
    output logic [NPHASE-1:0] o_next_phase,
    output logic              o_is_last
);

    logic w_seen;   // the active phase lies below the index being examined
    logic w_found;  // a candidate has already been selected

    always_comb begin
        o_next_phase = '0;
        w_seen       = 1'b0;
        w_found      = 1'b0;
        for (int j = 0; j < NPHASE; j++) begin
            if (w_seen && !i_mask[j] && !w_found) begin
                o_next_phase[j] = 1'b1;
                w_found         = 1'b1;
            end
            w_seen = w_seen | i_phase[j];
        end
        o_is_last = !w_found;
    end

endmodule : simple_next_phase
`default_nettype wire

// File: rtl/simple_phase_seq.sv
`default_nettype none
// ============================================================================
// Module      : simple_phase_seq
// Description : N-phase one-hot instruction sequencer for the SIMPLE core.
//               Supports memory stall, per-instruction phase skipping,
//               halt/restart and retired-instruction counting.
// Revision    : 1.0 - initial release
//
// Parameters  : NPHASE   number of phases (3..16); phase 0 fetch, 1 decode
//               CNT_W    counter width
// Ports       : clk          system clock
//               rst          asynchronous active-high reset
//               run_i        start request (IDLE/HALT only)
//               stall_i      hold the current phase
//               halt_i       halt at instruction completion
//               skip_mask_i  phases to skip, sampled while in decode
//               phase_o      one-hot active phase, zero when not running
//               instr_done_o pulse on the final cycle of each instruction
//               halted_o     high while halted
//               instr_cnt_o  retired-instruction count (wraps)
//               stall_cnt_o  saturating stall-cycle count
//                            (only with SIMPLE_SEQ_STALL_CNT_EN defined)
// ============================================================================
module simple_phase_seq
    import simple_pkg::*;
#(
    parameter int NPHASE = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run_i,
    input  logic              stall_i,
    input  logic              halt_i,
    input  logic [NPHASE-1:0] skip_mask_i,
    output logic [NPHASE-1:0] phase_o,
    output logic              instr_done_o,
    output logic              halted_o,
    output logic [CNT_W-1:0]  instr_cnt_o
`ifdef SIMPLE_SEQ_STALL_CNT_EN
   ,output logic [CNT_W-1:0]  stall_cnt_o
`endif
);

    // Fetch and decode can never be skipped
    localparam logic [NPHASE-1:0] c_mask_keep   = ~((NPHASE'(1) << PH_FETCH) |
                                                    (NPHASE'(1) << PH_DECODE));
    localparam logic [NPHASE-1:0] c_phase_fetch = NPHASE'(1) << PH_FETCH;

    seq_state_t        r_state;
    seq_state_t        w_state_nxt;
    logic [NPHASE-1:0] r_phase;
    logic [NPHASE-1:0] w_phase_nxt;
    logic [NPHASE-1:0] r_mask;
    logic [NPHASE-1:0] w_mask_nxt;
    logic [CNT_W-1:0]  r_instr_cnt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic [NPHASE-1:0] w_mask_eff;
    logic [NPHASE-1:0] w_next_phase;
    logic              w_is_last;
    logic              w_done;

    // While in decode the incoming mask already steers the transition out
    // of decode, so it is used directly instead of the latched copy.
    assign w_mask_eff = r_phase[PH_DECODE] ? (skip_mask_i & c_mask_keep) : r_mask;

    simple_next_phase #(
        .NPHASE (NPHASE)
    ) u_next_phase (
        .i_phase      (r_phase),
        .i_mask       (w_mask_eff),
        .o_next_phase (w_next_phase),
        .o_is_last    (w_is_last)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_phase     <= '0;
            r_mask      <= '0;
            r_instr_cnt <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_phase     <= w_phase_nxt;
            r_mask      <= w_mask_nxt;
            r_instr_cnt <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_phase_nxt = r_phase;
        w_mask_nxt  = r_mask;
        w_cnt_nxt   = r_instr_cnt;
        w_done      = 1'b0;
        case (r_state)
            IDLE, HALT: begin
                if (run_i) begin
                    w_state_nxt = RUN;
                    w_phase_nxt = c_phase_fetch;
                    w_mask_nxt  = '0;
                end
            end
            RUN: begin
                if (!stall_i) begin
                    if (w_is_last) begin
                        w_done     = 1'b1;
                        w_cnt_nxt  = r_instr_cnt + CNT_W'(1);
                        w_mask_nxt = '0;
                        if (halt_i) begin
                            w_state_nxt = HALT;
                            w_phase_nxt = '0;
                        end else begin
                            w_phase_nxt = c_phase_fetch;
                        end
                    end else begin
                        w_phase_nxt = w_next_phase;
                        if (r_phase[PH_DECODE]) begin
                            w_mask_nxt = w_mask_eff;
                        end
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_phase_nxt = '0;
                w_mask_nxt  = '0;
            end
        endcase
    end

    assign phase_o      = r_phase;
    assign instr_done_o = w_done;
    assign halted_o     = (r_state == HALT);
    assign instr_cnt_o  = r_instr_cnt;

`ifdef SIMPLE_SEQ_STALL_CNT_EN
    logic [CNT_W-1:0] r_stall_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt <= '0;
        end else if ((r_state == RUN) && stall_i && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end

    assign stall_cnt_o = r_stall_cnt;
`else
    // Stall-cycle counting is not built in this configuration.
`endif

endmodule : simple_phase_seq
`default_nettype wire

// File: tb/tb_simple_phase_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_simple_phase_seq
// Description : Self-checking bench for simple_phase_seq (NPHASE=5, CNT_W=4).
//               The stimulus process pushes the expected per-cycle phase,
//               done pulse and instruction count into a queue; a monitor
//               pops and compares on every cycle the DUT shows an active phase.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_simple_phase_seq;

    typedef struct packed {
        logic [4:0] ph;
        logic       d;
        logic [3:0] c;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       run_i = 1'b0;
    logic       stall_i = 1'b0;
    logic       halt_i = 1'b0;
    logic [4:0] skip_mask_i = '0;
    logic [4:0] phase_o;
    logic       instr_done_o;
    logic       halted_o;
    logic [3:0] instr_cnt_o;
`ifdef SIMPLE_SEQ_STALL_CNT_EN
    logic [3:0] stall_cnt_o;
`endif

    int   total = 0;
    int   bad   = 0;
    exp_t q[$];

    simple_phase_seq #(
        .NPHASE (5),
        .CNT_W  (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .run_i        (run_i),
        .stall_i      (stall_i),
        .halt_i       (halt_i),
        .skip_mask_i  (skip_mask_i),
        .phase_o      (phase_o),
        .instr_done_o (instr_done_o),
        .halted_o     (halted_o),
        .instr_cnt_o  (instr_cnt_o)
`ifdef SIMPLE_SEQ_STALL_CNT_EN
       ,.stall_cnt_o  (stall_cnt_o)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic expect_cycle(input logic [4:0] ph, input logic d, input logic [3:0] c);
        exp_t e;
        e.ph = ph;
        e.d  = d;
        e.c  = c;
        q.push_back(e);
    endtask

    // Apply inputs for the current cycle, then move to #1 after the next edge
    task automatic drive(input logic r, input logic s, input logic h, input logic [4:0] m);
        run_i       = r;
        stall_i     = s;
        halt_i      = h;
        skip_mask_i = m;
        @(posedge clk);
        #1;
    endtask

    // Monitor: compares whenever the sequencer presents an active phase
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && (phase_o != 5'b0)) begin
                if (q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_phase actual=%b expected=none", phase_o);
                end else begin
                    e = q.pop_front();
                    check("phase", 32'(phase_o), 32'(e.ph));
                    check("instr_done", 32'(instr_done_o), 32'(e.d));
                    check("instr_cnt", 32'(instr_cnt_o), 32'(e.c));
                end
            end else if (!rst && instr_done_o) begin
                total++;
                bad++;
                $display("FAIL done_while_idle actual=1 expected=0");
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state
        #3;
        check("rst_phase", 32'(phase_o), 32'd0);
        check("rst_done", 32'(instr_done_o), 32'd0);
        check("rst_halted", 32'(halted_o), 32'd0);
        check("rst_cnt", 32'(instr_cnt_o), 32'd0);
`ifdef SIMPLE_SEQ_STALL_CNT_EN
        check("rst_stall_cnt", 32'(stall_cnt_o), 32'd0);
`endif
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Start: one-cycle run pulse
        drive(1'b1, 1'b0, 1'b0, 5'b0);

        // Instruction 1: all five phases
        expect_cycle(5'b00001, 1'b0, 4'd0); drive(1'b0, 1'b0, 1'b0, 5'b0);
        expect_cycle(5'b00010, 1'b0, 4'd0); drive(1'b0, 1'b0, 1'b0, 5'b0);
        expect_cycle(5'b00100, 1'b0, 4'd0); drive(1'b0, 1'b0, 1'b0, 5'b0);
        expect_cycle(5'b01000, 1'b0, 4'd0); drive(1'b0, 1'b0, 1'b0, 5'b0);
        expect_cycle(5'b10000, 1'b1, 4'd0); drive(1'b0, 1'b0, 1'b0, 5'b0);

        // Instruction 2: skip phases 2 and 3; mask outside decode is ignored
        expect_cycle(5'b00001, 1'b0, 4'd1); drive(1'b0, 1'b0, 1'b0, 5'b11111);
        expect_cycle(5'b00010, 1'b0, 4'd1); drive(1'b0, 1'b0, 1'b0, 5'b01100);
        expect_cycle(5'b10000, 1'b1, 4'd1); drive(1'b0, 1'b0, 1'b0, 5'b0);

        // Instruction 3: full, three stall cycles in phase 2
        expect_cycle(5'b00001, 1'b0, 4'd2); drive(1'b0, 1'b0, 1'b0, 5'b0);
        expect_cycle(5'b00010, 1'b0, 4'd2); drive(1'b0, 1'b0, 1'b0, 5'b0);
        for (int i = 0; i < 3; i++) begin
            expect_cycle(5'b00100, 1'b0, 4'd2); drive(1'b0, 1'b1, 1'b0, 5'b0);
        end
        expect_cycle(5'b00100, 1'b0, 4'd2); drive(1'b0, 1'b0, 1'b0, 5'b0);
        expect_cycle(5'b01000, 1'b0, 4'd2); drive(1'b0, 1'b0, 1'b0, 5'b0);
        expect_cycle(5'b10000, 1'b1, 4'd2); drive(1'b0, 1'b0, 1'b0, 5'b0);
`ifdef SIMPLE_SEQ_STALL_CNT_EN
        check("stall_cnt", 32'(stall_cnt_o), 32'd3);
`endif

        // Instruction 4: phases 2..4 skipped, completes in decode
        expect_cycle(5'b00001, 1'b0, 4'd3); drive(1'b0, 1'b0, 1'b0, 5'b0);
        expect_cycle(5'b00010, 1'b1, 4'd3); drive(1'b0, 1'b0, 1'b0, 5'b11100);

        // Instruction 5: early halt ignored, run ignored, halt at completion
        expect_cycle(5'b00001, 1'b0, 4'd4); drive(1'b0, 1'b0, 1'b0, 5'b0);
        expect_cycle(5'b00010, 1'b0, 4'd4); drive(1'b0, 1'b0, 1'b0, 5'b0);
        expect_cycle(5'b00100, 1'b0, 4'd4); drive(1'b0, 1'b0, 1'b1, 5'b0);
        expect_cycle(5'b01000, 1'b0, 4'd4); drive(1'b1, 1'b0, 1'b0, 5'b0);
        expect_cycle(5'b10000, 1'b1, 4'd4); drive(1'b0, 1'b0, 1'b1, 5'b0);

        // Halted
        check("halt_phase", 32'(phase_o), 32'd0);
        check("halt_halted", 32'(halted_o), 32'd1);
        check("halt_cnt", 32'(instr_cnt_o), 32'd5);
        drive(1'b0, 1'b0, 1'b0, 5'b0);
        check("halt_hold", 32'(halted_o), 32'd1);
        drive(1'b1, 1'b0, 1'b0, 5'b0);

        // Instructions 6..16: short instructions until the counter wraps
        for (int k = 5; k < 16; k++) begin
            expect_cycle(5'b00001, 1'b0, 4'(k));
            if (k == 5) check("restart_halted", 32'(halted_o), 32'd0);
            drive(1'b0, 1'b0, 1'b0, 5'b0);
            expect_cycle(5'b00010, 1'b1, 4'(k));
            drive(1'b0, 1'b0, 1'b0, 5'b11100);
        end
        check("cnt_wrap", 32'(instr_cnt_o), 32'd0);

        // Instruction 17: reset in the middle of phase 2
        expect_cycle(5'b00001, 1'b0, 4'd0); drive(1'b0, 1'b0, 1'b0, 5'b0);
        expect_cycle(5'b00010, 1'b0, 4'd0); drive(1'b0, 1'b0, 1'b0, 5'b0);
        check("pre_rst_phase", 32'(phase_o), 32'b00100);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_phase", 32'(phase_o), 32'd0);
        check("async_rst_done", 32'(instr_done_o), 32'd0);
        check("async_rst_halted", 32'(halted_o), 32'd0);
`ifdef SIMPLE_SEQ_STALL_CNT_EN
        check("async_rst_stall_cnt", 32'(stall_cnt_o), 32'd0);
`endif
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Stays idle without a run request
        drive(1'b0, 1'b0, 1'b0, 5'b0);
        drive(1'b0, 1'b0, 1'b0, 5'b0);
        drive(1'b0, 1'b0, 1'b0, 5'b0);
        check("idle_phase", 32'(phase_o), 32'd0);
        check("idle_cnt", 32'(instr_cnt_o), 32'd0);
        check("queue_drained", 32'(q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_simple_phase_seq
`default_nettype wire

// File: doc/simple_phase_seq.md
# simple_phase_seq

Parametrised multi-phase instruction sequencer for the SIMPLE processor core; it generalises the fixed 5-phase counter into an N-phase one-hot sequencer. Features: memory stall, per-instruction phase skipping, halt/restart, and retired-instruction counting. It sits between the decode logic and the datapath and drives the phase enables that gate PC update, RAM access, register-file write and ALU capture.

## Interface
- NPHASE, 5, number of phases; legal range 3..16. Phase 0 is fetch, phase 1 is decode.
- CNT_W, 16, width of the retired-instruction counter.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous and active-high; clears all state immediately.
- run_i  in  1  start request; honoured only in IDLE or HALT.
- stall_i  in  1  hold the current phase (memory not ready).
- halt_i  in  1  halt request from decode; acted on at instruction completion.
- skip_mask_i  in  NPHASE  phases to skip for the current instruction; bits 0 and 1 are ignored.
- phase_o  out  NPHASE  one-hot active phase; all-zero when not running.
- instr_done_o  out  1  single-cycle pulse on the final cycle of each instruction.
- halted_o  out  1  high in HALT.
- instr_cnt_o  out  CNT_W  retired-instruction count.
- stall_cnt_o  out  CNT_W  saturating stall-cycle count; present only with SIMPLE_SEQ_STALL_CNT_EN.

## Operation
- FSM states: IDLE, RUN, HALT.
- Reset values:
  - state = IDLE
  - phase_o = 0
  - instr_done_o = 0
  - halted_o = 0
  - instr_cnt_o = 0
  - stall_cnt_o = 0
  - latched skip mask = 0
- IDLE/HALT with run_i=1: next state RUN, phase_o = one-hot bit 0. halted_o drops in the same edge.
- RUN, stall_i=1: phase_o, the latched mask and the counters hold; instr_done_o = 0.
- RUN, stall_i=0: advance to the next higher phase index whose latched-mask bit is 0.
- Mask latching:
  - The mask is latched from skip_mask_i on the edge leaving phase 1.
  - Leaving phase 1 already uses the new mask to choose the next phase.
  - Bits 0 and 1 are forced to 0 when latched.
- Last phase: the highest unskipped index (NPHASE-1 if its bit is clear). If all of phases 2..NPHASE-1 are skipped, phase 1 is the last phase.
- In the last phase with stall_i=0:
  - instr_done_o = 1 (combinational from state, phase and stall).
  - instr_cnt_o increments on that edge; it wraps from 2^CNT_W-1 to 0.
  - If halt_i=1 in that same cycle, the next state is HALT with phase_o = 0 and halted_o = 1.
  - Otherwise phase_o returns to bit 0 and the latched mask clears.
- halt_i in any other cycle is ignored; decode must hold it through completion.
- run_i while in RUN is ignored.
- Asserting rst mid-instruction aborts immediately: phase_o = 0 and counters are cleared.

## Timing
- phase_o, halted_o and the counters are registered.
- Start: run_i sampled at edge k → phase 0 is active in cycle k+1.
- Unstalled instruction with s skipped phases: NPHASE − s cycles from phase 0 to instr_done_o.
- Each stall cycle adds exactly one cycle.
- Halt-to-restart: at least 1 cycle in HALT before run_i can take effect.

## Configuration
- SIMPLE_SEQ_STALL_CNT_EN defined:
  - Adds the stall_cnt_o port and register.
  - Increments on every RUN cycle with stall_i=1 and saturates at 2^CNT_W-1.
  - Cleared only by rst.
- Undefined: the port and register do not exist; all other behaviour is identical.

## Structure
- Package simple_pkg holds:
  - the seq_state_t enum (IDLE, RUN, HALT)
  - constants PH_FETCH = 0 and PH_DECODE = 1
  - the NPHASE_MAX = 16 bound
- One sub-module, simple_next_phase: combinational priority search that takes the current one-hot phase and the mask and returns the next one-hot phase plus an is_last flag.

## Test plan
- Reset/start: rst pulse mid-cycle → all outputs 0 asynchronously. run_i=1 for one cycle → phase_o sequence 00001, 00010, 00100, 01000, 10000, 00001; instr_done_o high only in the 10000 cycle; instr_cnt_o = 1 after it.
- Skip: skip_mask_i=5'b01100 at decode → phases 00001, 00010, 10000; instr_done_o on 10000. Next instruction with mask 0 runs all 5 phases.
- Stall: stall_i=1 for 3 cycles during 00100 → phase held 4 cycles total, no instr_done_o. With the macro defined, stall_cnt_o = 3.
- Halt: halt_i=1 in the final phase → phase_o = 0 and halted_o = 1 next cycle. run_i=1 → phase 00001 next cycle, halted_o = 0.
- Edge cases:
  - CNT_W=4: 16 instructions → instr_cnt_o wraps to 0.
  - Mask 11100: instruction completes in phase 1 (2 cycles).
  - rst during phase 00100: phase_o = 0 immediately.
